decode_stage: RTL

- Registered, handshaked MIPS decode stage. Sits between the fetch stage (upstream valid/ready) and the execute stage (downstream valid/ready).
- Each accepted instruction is split into fields and decoded into a full control bundle. The immediate is extended to DATA_W.
- The whole bundle is held in one output register.
- Adds load-use hazard stalling, branch/jump flush, an illegal-opcode flag and saturating performance counters.

---
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// MIPS decode stage: splits and decodes one instruction per accept into a registered
// control bundle, with load-use stalling, flush, illegal flag and saturating counters.
module decode_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ALUOP_W  = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned LINK_REG = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [DATA_W-1:0]  in_pc4,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_pc4,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_dest,
  output logic [4:0]         out_shamt,
  output logic [DATA_W-1:0]  out_imm,
  output logic [25:0]        out_adr,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic               out_alu_src_imm,
  output logic               out_regwrite,
  output logic               out_memread,
  output logic               out_memwrite,
  output logic               out_beq,
  output logic               out_bne,
  output logic               out_jump,
  output logic               out_link,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   issue_cnt
);

  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluSll = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AluSrl = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] AluLui = ALUOP_W'(6);

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  assign op    = in_instr[31:26];
  assign rs    = in_instr[25:21];
  assign rt    = in_instr[20:16];
  assign rd    = in_instr[15:11];
  assign funct = in_instr[5:0];

  logic [DATA_W-1:0] imm_sext, imm_zext, imm_lui;
  assign imm_sext = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
  assign imm_zext = {{(DATA_W-16){1'b0}}, in_instr[15:0]};
  assign imm_lui  = DATA_W'({in_instr[15:0], 16'h0000});

  logic [ALUOP_W-1:0] alu_op_d;
  logic [DATA_W-1:0]  imm_d;
  logic [4:0]         dest_d;
  logic alu_src_d, regwrite_d, memread_d, memwrite_d, beq_d, bne_d, jump_d, link_d, illegal_d;

  always_comb begin
    alu_op_d   = AluAdd;
    imm_d      = imm_sext;
    dest_d     = 5'd0;
    alu_src_d  = 1'b0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    beq_d      = 1'b0;
    bne_d      = 1'b0;
    jump_d     = 1'b0;
    link_d     = 1'b0;
    illegal_d  = 1'b0;
    case (op)
      6'h00: begin
        regwrite_d = 1'b1;
        dest_d     = rd;
        case (funct)
          6'h20, 6'h21: alu_op_d = AluAdd;
          6'h22:        alu_op_d = AluSub;
          6'h24:        alu_op_d = AluAnd;
          6'h25:        alu_op_d = AluOr;
          6'h00:        alu_op_d = AluSll;
          6'h02:        alu_op_d = AluSrl;
          default: begin
            illegal_d  = 1'b1;
            regwrite_d = 1'b0;
            dest_d     = 5'd0;
          end
        endcase
      end
      6'h08, 6'h09: begin
        alu_src_d = 1'b1; regwrite_d = 1'b1; dest_d = rt;
      end
      6'h0C: begin
        alu_op_d = AluAnd; imm_d = imm_zext; alu_src_d = 1'b1; regwrite_d = 1'b1; dest_d = rt;
      end
      6'h0D: begin
        alu_op_d = AluOr; imm_d = imm_zext; alu_src_d = 1'b1; regwrite_d = 1'b1; dest_d = rt;
      end
      6'h0F: begin
        alu_op_d = AluLui; imm_d = imm_lui; alu_src_d = 1'b1; regwrite_d = 1'b1; dest_d = rt;
      end
      6'h23: begin
        alu_src_d = 1'b1; memread_d = 1'b1; regwrite_d = 1'b1; dest_d = rt;
      end
      6'h2B: begin
        alu_src_d = 1'b1; memwrite_d = 1'b1;
      end
      6'h04: begin
        alu_op_d = AluSub; beq_d = 1'b1;
      end
      6'h05: begin
        alu_op_d = AluSub; bne_d = 1'b1;
      end
      6'h02: jump_d = 1'b1;
      6'h03: begin
        jump_d = 1'b1; link_d = 1'b1; regwrite_d = 1'b1; dest_d = 5'(LINK_REG);
      end
      default: illegal_d = 1'b1;
    endcase
    // Writes to $0 are architecturally dropped.
    if (dest_d == 5'd0) regwrite_d = 1'b0;
  end

  logic uses_rt, hazard, load;
  assign uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
  assign hazard  = out_valid && out_memread && (out_dest != 5'd0) && in_valid &&
                   ((rs == out_dest) || (uses_rt && (rt == out_dest)));
  assign in_ready = !rst && (flush || ((!out_valid || out_ready) && !hazard));
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_pc4         <= '0;
      out_rs          <= '0;
      out_rt          <= '0;
      out_dest        <= '0;
      out_shamt       <= '0;
      out_imm         <= '0;
      out_adr         <= '0;
      out_alu_op      <= '0;
      out_alu_src_imm <= 1'b0;
      out_regwrite    <= 1'b0;
      out_memread     <= 1'b0;
      out_memwrite    <= 1'b0;
      out_beq         <= 1'b0;
      out_bne         <= 1'b0;
      out_jump        <= 1'b0;
      out_link        <= 1'b0;
      out_illegal     <= 1'b0;
      stall_cnt       <= '0;
      issue_cnt       <= '0;
    end else begin
      if (load) begin
        out_valid       <= 1'b1;
        out_pc4         <= in_pc4;
        out_rs          <= rs;
        out_rt          <= rt;
        out_dest        <= dest_d;
        out_shamt       <= in_instr[10:6];
        out_imm         <= imm_d;
        out_adr         <= in_instr[25:0];
        out_alu_op      <= alu_op_d;
        out_alu_src_imm <= alu_src_d;
        out_regwrite    <= regwrite_d;
        out_memread     <= memread_d;
        out_memwrite    <= memwrite_d;
        out_beq         <= beq_d;
        out_bne         <= bne_d;
        out_jump        <= jump_d;
        out_link        <= link_d;
        out_illegal     <= illegal_d;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
      if (hazard && !flush && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (out_valid && out_ready && (issue_cnt != {CNT_W{1'b1}})) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

endmodule
